seq_detect_param: RTL and testbench

//   Parametrised serial sequence detector: samples one bit per enabled cycle and

---
 rtl/seq_detect_param.sv | 88 ++++++++
 tb/tb_seq_detect_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with runtime-loadable pattern,
// overlapping / non-overlapping match modes and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned       W       = 5,
  parameter logic [W-1:0]      PATTERN = 5'b10110,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             overlap,
  input  logic             load,
  input  logic [W-1:0]     pat_in,
  input  logic             clr_cnt,
  output logic             o,
  output logic [CNT_W-1:0] cnt,
  output logic [W-1:0]     pat
);

  // fill counts 0..W valid history bits
  localparam int unsigned FW = $clog2(W + 1);

  logic [W-1:0]     pat_q,  pat_d;
  logic [W-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             o_q,    o_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [W-1:0]     hist_shift_c;
  logic [FW-1:0]    fill_inc_c;
  logic             match_c;

  // Candidate history/fill for an enabled sample and the resulting match
  always_comb begin
    hist_shift_c = {hist_q[W-2:0], i};
    fill_inc_c   = (fill_q == FW'(W)) ? fill_q : fill_q + FW'(1);
    match_c      = en && !load && (fill_inc_c == FW'(W)) && (hist_shift_c == pat_q);
  end

  // Next-state: load restarts detection, enabled cycles shift, idle cycles hold
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    o_d    = 1'b0;
    cnt_d  = cnt_q;

    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift_c;
      fill_d = (match_c && !overlap) ? '0 : fill_inc_c;
      o_d    = match_c;
    end

    // Counter clear has priority over counting the current match
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      o_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      o_q    <= o_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o   = o_q;
  assign cnt = cnt_q;
  assign pat = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: vector table, directed corner cases and
// randomized stimulus against a queue-based reference model.
module tb_seq_detect_param;

  localparam int unsigned W     = 5;
  localparam int unsigned CNT_W = 8;
  localparam logic [W-1:0] P    = 5'b10110;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, i, overlap, load, clr_cnt;
  logic [W-1:0]     pat_in;
  logic             o;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     pat;
  logic             o2;
  logic [1:0]       cnt2;
  logic [W-1:0]     pat2;

  int checks = 0;
  int errors = 0;

  seq_detect_param #(.W(W), .PATTERN(P), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .i(i), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .o(o), .cnt(cnt), .pat(pat)
  );

  seq_detect_param #(.W(W), .PATTERN(5'b11111), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .i(i), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .o(o2), .cnt(cnt2), .pat(pat2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic             i;
    logic             ov;
    logic             ld;
    logic [W-1:0]     pin;
    logic             clr;
    logic             exp_o;
    logic [CNT_W-1:0] exp_cnt;
    logic [W-1:0]     exp_pat;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  bit               mq[$];
  logic [W-1:0]     mpat;
  logic [CNT_W-1:0] mcnt;
  logic             mo;

  function automatic vec_t mk(logic e, logic b, logic ov, logic ld, logic [W-1:0] p,
                              logic c, logic eo, int ec);
    vec_t v;
    v.en = e; v.i = b; v.ov = ov; v.ld = ld; v.pin = p; v.clr = c;
    v.exp_o = eo; v.exp_cnt = CNT_W'(ec); v.exp_pat = P;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // apply one cycle of inputs from a negedge, return at the following negedge
  task automatic drive(input logic e, input logic b, input logic ov, input logic ld,
                       input logic [W-1:0] p, input logic c);
    en = e; i = b; overlap = ov; load = ld; pat_in = p; clr_cnt = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; i = 1'b0; overlap = 1'b0; load = 1'b0;
    pat_in = '0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] qval();
    logic [W-1:0] v = '0;
    foreach (mq[k]) v = {v[W-2:0], mq[k]};
    return v;
  endfunction

  // model: keep the bits received since the last restart, at most W of them
  task automatic model_step(input logic e, input logic b, input logic ov, input logic ld,
                            input logic [W-1:0] p, input logic c);
    bit m = 1'b0;
    if (ld) begin
      mpat = p;
      mq.delete();
      mo = 1'b0;
    end else if (e) begin
      mq.push_back(b);
      if (mq.size() > W) void'(mq.pop_front());
      m = (mq.size() == W) && (qval() == mpat);
      mo = m;
      if (m && !ov) mq.delete();
    end else begin
      mo = 1'b0;
    end
    if (c) mcnt = '0;
    else if (m && (int'(mcnt) < (1 << CNT_W) - 1)) mcnt = mcnt + CNT_W'(1);
  endtask

  initial begin
    logic [1:0] exp_c2 [9];
    do_reset();

    // reset state
    chk("reset_o", 32'(o), 32'(0));
    chk("reset_cnt", 32'(cnt), 32'(0));
    chk("reset_pat", 32'(pat), 32'(P));

    // overlapping stream 1,0,1,1,0,1,1,0
    tbl.push_back(mk(1,1,1,0,0,0, 0,0)); tbl.push_back(mk(1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,0,0,0, 0,0)); tbl.push_back(mk(1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0,0, 1,1)); tbl.push_back(mk(1,1,1,0,0,0, 0,1));
    tbl.push_back(mk(1,1,1,0,0,0, 0,1)); tbl.push_back(mk(1,0,1,0,0,0, 1,2));
    // restart, then same stream non-overlapping
    tbl.push_back(mk(1,1,1,1,P,0, 0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 0,2)); tbl.push_back(mk(1,0,0,0,0,0, 0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 0,2)); tbl.push_back(mk(1,1,0,0,0,0, 0,2));
    tbl.push_back(mk(1,0,0,0,0,0, 1,3)); tbl.push_back(mk(1,1,0,0,0,0, 0,3));
    tbl.push_back(mk(1,1,0,0,0,0, 0,3)); tbl.push_back(mk(1,0,0,0,0,0, 0,3));
    // restart, then 1,0,1,1,0 with idle cycles (i ignored) between bits
    tbl.push_back(mk(1,1,0,1,P,0, 0,3));
    tbl.push_back(mk(1,1,0,0,0,0, 0,3)); tbl.push_back(mk(0,1,0,0,0,0, 0,3));
    tbl.push_back(mk(1,0,0,0,0,0, 0,3)); tbl.push_back(mk(0,0,0,0,0,0, 0,3));
    tbl.push_back(mk(1,1,0,0,0,0, 0,3)); tbl.push_back(mk(0,0,0,0,0,0, 0,3));
    tbl.push_back(mk(1,1,0,0,0,0, 0,3)); tbl.push_back(mk(0,1,0,0,0,0, 0,3));
    tbl.push_back(mk(1,0,0,0,0,0, 1,4)); tbl.push_back(mk(0,0,0,0,0,0, 0,4));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0));

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].i, tbl[k].ov, tbl[k].ld, tbl[k].pin, tbl[k].clr);
      chk($sformatf("tbl%0d_o", k), 32'(o), 32'(tbl[k].exp_o));
      chk($sformatf("tbl%0d_cnt", k), 32'(cnt), 32'(tbl[k].exp_cnt));
      chk($sformatf("tbl%0d_pat", k), 32'(pat), 32'(tbl[k].exp_pat));
    end

    // all-zero pattern: partial history never matches
    do_reset();
    drive(0, 0, 1, 1, 5'b00000, 0);
    chk("zero_load_pat", 32'(pat), 32'(0));
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0, 0, 0);
      chk($sformatf("zero_partial%0d_o", k), 32'(o), 32'(0));
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0, 0, 0);
      chk($sformatf("zero_match%0d_o", k), 32'(o), 32'(1));
      chk($sformatf("zero_match%0d_cnt", k), 32'(cnt), 32'(k + 1));
    end

    // 2-bit counter saturation on all-ones pattern
    do_reset();
    exp_c2 = '{0, 0, 0, 0, 1, 2, 3, 3, 3};
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 1, 0, 0, 0);
      chk($sformatf("sat%0d_o", k), 32'(o2), 32'(k >= 4 ? 1 : 0));
      chk($sformatf("sat%0d_cnt", k), 32'(cnt2), 32'(exp_c2[k]));
    end
    drive(1, 1, 1, 0, 0, 1);
    chk("sat_clr_o", 32'(o2), 32'(1));
    chk("sat_clr_cnt", 32'(cnt2), 32'(0));

    // reset mid-sequence loses history
    do_reset();
    drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_mid_o", 32'(o), 32'(0));

    // asynchronous drop of o on reset
    drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_async_pre_o", 32'(o), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_o", 32'(o), 32'(0));
    chk("rst_async_cnt", 32'(cnt), 32'(0));
    @(negedge clk) rst = 1'b0;

    // load mid-sequence discards its bit and restarts the fill
    drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, P, 0);
    chk("load_mid_o", 32'(o), 32'(0));
    drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    chk("load_mid_nomatch_o", 32'(o), 32'(0));
    drive(1, 1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    chk("load_mid_partial_o", 32'(o), 32'(0));
    drive(1, 0, 0, 0, 0, 0);
    chk("load_mid_match_o", 32'(o), 32'(1));

    // randomized run against the reference model
    do_reset();
    mq.delete(); mpat = P; mcnt = '0; mo = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic e, b, ov, ld, c;
      logic [W-1:0] p;
      e  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      ov = 1'($urandom);
      ld = ($urandom_range(0, 63) == 0);
      p  = W'($urandom);
      c  = ($urandom_range(0, 99) == 0);
      drive(e, b, ov, ld, p, c);
      model_step(e, b, ov, ld, p, c);
      chk($sformatf("rnd%0d_o", n), 32'(o), 32'(mo));
      chk($sformatf("rnd%0d_cnt", n), 32'(cnt), 32'(mcnt));
      chk($sformatf("rnd%0d_pat", n), 32'(pat), 32'(mpat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
